hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Multi-cycle multiply/divide engine that owns the architectural HI and LO registers and sequences every HI/LO-class instruction: mult, multu, madd, msub, mthi, mtlo, and optionally div/divu. It sits beside the single-cycle ALU in the EX stage. Long operations iterate over 32 cycles, and the unit raises a stall to the hazard logic when an mfhi/mflo would read HI/LO before the result is written.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- start_i  in  1  the EX stage presents an HI/LO op this cycle.
- op_i  in  4  operation code (see Structure).
- rs_i  in  32  operand A (rs).
- rt_i  in  32  operand B (rt).
- flush_i  in  1  cancels any in-flight op.
- rd_req_i  in  1  mfhi or mflo is in EX this cycle.
- ready_o  out  1  unit idle; start_i is accepted.
- busy_o  out  1  iterative op in flight.
- stall_o  out  1  busy_o & rd_req_i (combinational).
- done_o  out  1  one-cycle pulse on the edge HI/LO receive an iterative result.
- hi_o  out  32  current HI register.
- lo_o  out  32  current LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - An op is accepted when start_i & ready_o. ready_o = (state==IDLE).
  - MTHI writes HI←rs_i on the accept edge; MTLO writes LO←rs_i. Both stay in IDLE and assert no busy.
  - MULT, MULTU, MADD, MSUB, DIV, DIVU latch the operands and go to CALC with count=0.
  - NOP and undefined codes do nothing.
- Signed ops (MULT, MADD, MSUB, DIV) work on magnitudes and record the sign(s). Unsigned ops use the raw values.
- CALC, multiply: radix-2 shift-add over a 64-bit product register, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC lasts exactly 32 cycles; it moves to FIX when count==31.
- FIX applies sign correction, then writes HI/LO:
  - MULT/MULTU: {HI,LO}←P.
  - MADD: {HI,LO}←{HI,LO}+P.
  - MSUB: {HI,LO}←{HI,LO}−P.
  - All 64-bit sums wrap modulo 2^64.
  - DIV/DIVU: LO←quotient, HI←remainder. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - FIX pulses done_o and returns to IDLE.
- Divide by zero (rt_i==0): detected at accept. No state change, HI/LO unchanged, no busy, no done.
- flush_i in CALC or FIX: return to IDLE on the next edge, HI/LO unchanged, no done_o. flush_i in IDLE has no effect; a same-cycle MTHI/MTLO is still performed.
- start_i while busy is ignored. The hazard unit must hold the instruction using stall_o/ready_o.
- Reset, including mid-operation: state=IDLE, HI=LO=0, count=0, busy_o=0, done_o=0, ready_o=1.

## Timing
- An iterative op accepted at edge 0 sets busy_o=1 from edge 0.
- CALC edges: 1..32. FIX edge: 33 writes HI/LO and pulses done_o; busy_o returns to 0 after edge 33.
- Iterative-op latency is therefore 33 cycles. A back-to-back op can be accepted at edge 34.
- MTHI/MTLO take 1 cycle; the new value is visible on hi_o/lo_o after the accept edge.
- hi_o and lo_o are register outputs. stall_o is combinational from busy_o and rd_req_i.

## Configuration
- HILO_DIV_EN defined: DIV/DIVU are implemented as described.
- HILO_DIV_EN undefined: the divide datapath is not instantiated. Op codes 7/8 behave as NOP: no state change, no busy.

## Structure
- Package hilo_pkg holds:
  - Op constants: OP_NOP=0, OP_MULT=1, OP_MULTU=2, OP_MADD=3, OP_MSUB=4, OP_MTHI=5, OP_MTLO=6, OP_DIV=7, OP_DIVU=8.
  - State encoding.
  - ITER=32.
- Sub-module hilo_iter_core holds the shared shift/add/subtract datapath: product/remainder register, count, and a mul/div select. The top level holds the FSM, sign handling, HI/LO, and the handshake.

## Test plan
- MULT rs=0xFFFFFFFD (−3), rt=5 -> at edge 33 HI=0xFFFFFFFF, LO=0xFFFFFFF1, done_o pulses once.
- MULTU rs=0xFFFFFFFF, rt=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- MTHI 0, MTLO 10, then MADD 4×5 -> HI=0, LO=0x1E. Then MSUB 1×0x1F -> HI=LO=0xFFFFFFFF.
- MULT started, rd_req_i held high -> stall_o=1 for edges 0..33, then 0. flush_i at cycle 10 -> busy_o drops, HI/LO keep their prior values.
- With HILO_DIV_EN: DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU x/0 -> no busy, HI/LO unchanged.
- Rst asserted at cycle 15 of a MULT -> immediately HI=LO=0, busy_o=0, ready_o=1. A new MULT is accepted on the first edge after release.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, iteration count.
package hilo_pkg;

  localparam int ITER = 32;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MSUB  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Shared shift/add (multiply) and restoring-subtract (divide) datapath, one bit per step.
// Divide path is present only when HILO_DIV_EN is defined.
module hilo_iter_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [4:0]           count_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic [4:0]         count_q;
  logic [WIDTH:0]     mul_sum;

`ifdef HILO_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
`else
  logic               unused_div;
  assign unused_div = div_i;
`endif

  // NOTE: every variable written in always_comb is given a default first so no latch is inferred.
  always_comb begin
    // Multiply: {carry, hi + (lsb ? mcand : 0), lo} shifted right one place.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef HILO_DIV_EN
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (div_q) begin
      if (div_shift >= {1'b0, b_q}) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                          acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      b_q     <= '0;
      count_q <= '0;
`ifdef HILO_DIV_EN
      div_q   <= 1'b0;
`endif
    end else if (load_i) begin
      acc_q   <= {{WIDTH{1'b0}}, a_i};
      b_q     <= b_i;
      count_q <= '0;
`ifdef HILO_DIV_EN
      div_q   <= div_i;
`endif
    end else if (step_i) begin
      acc_q   <= acc_d;
      count_q <= count_q + 5'd1;
    end
  end

  assign acc_o   = acc_q;
  assign count_o = count_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: sequences mult/multu/madd/msub/mthi/mtlo and, with HILO_DIV_EN defined, div/divu.
// Holds the FSM, sign handling and the EX-stage handshake; the iteration lives in hilo_iter_core.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  input  logic             rd_req_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e             state_q;
  logic [3:0]         op_q;
  logic               neg_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               accept, launch, is_signed, is_mul_op, is_div_op;
  logic [2*WIDTH-1:0] acc, prod, fix_d;
  logic [4:0]         count;

  assign is_signed = (op_i == OP_MULT) || (op_i == OP_MADD) || (op_i == OP_MSUB) || (op_i == OP_DIV);
  assign is_mul_op = (op_i == OP_MULT) || (op_i == OP_MULTU) || (op_i == OP_MADD) || (op_i == OP_MSUB);
`ifdef HILO_DIV_EN
  assign is_div_op = (op_i == OP_DIV) || (op_i == OP_DIVU);
`else
  assign is_div_op = 1'b0;
`endif

  assign accept = start_i && (state_q == ST_IDLE);
  // A zero divisor is rejected here so the unit never enters CALC for it.
  assign launch = accept && (is_mul_op || (is_div_op && (rt_i != '0)));

  hilo_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (launch),
    .step_i  ((state_q == ST_CALC) && !flush_i),
    .div_i   (is_div_op),
    .a_i     (mag32(rs_i, is_signed)),
    .b_i     (mag32(rt_i, is_signed)),
    .acc_o   (acc),
    .count_o (count)
  );

  assign prod = neg_q ? ('0 - acc) : acc;

  always_comb begin
    fix_d = prod;
    case (op_q)
      OP_MADD: fix_d = {hi_q, lo_q} + prod;
      OP_MSUB: fix_d = {hi_q, lo_q} - prod;
`ifdef HILO_DIV_EN
      OP_DIV, OP_DIVU: begin
        fix_d[WIDTH-1:0]       = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        fix_d[2*WIDTH-1:WIDTH] = neg_rem_q ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      end
`endif
      default: fix_d = prod;
    endcase
  end

`ifndef HILO_DIV_EN
  logic unused_neg_rem;
  assign unused_neg_rem = neg_rem_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && op_i == OP_MTHI) hi_q <= rs_i;
          if (accept && op_i == OP_MTLO) lo_q <= rs_i;
          if (launch) begin
            op_q      <= op_i;
            neg_q     <= is_signed && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
            neg_rem_q <= is_signed && rs_i[WIDTH-1];
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (flush_i)                       state_q <= ST_IDLE;
          else if (count == 5'(ITER - 1))    state_q <= ST_FIX;
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          if (!flush_i) begin
            {hi_q, lo_q} <= fix_d;
            done_q       <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = (state_q != ST_IDLE);
  assign stall_o = busy_o && rd_req_i;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit; divide vectors run only when HILO_DIV_EN is defined.
module tb_hilo_muldiv_unit;

  localparam logic [3:0] OP_NOP = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_MADD = 4'd3,
                         OP_MSUB = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_DIV = 4'd7,
                         OP_DIVU = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  op_i = OP_NOP;
  logic [31:0] rs_i = '0, rt_i = '0;
  logic        flush_i = 1'b0, rd_req_i = 1'b0;
  logic        ready_o, busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .flush_i(flush_i), .rd_req_i(rd_req_i), .ready_o(ready_o), .busy_o(busy_o),
    .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  // Presents one op for a single accept edge (edge 0); returns #1 after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_i = op; rs_i = a; rt_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = OP_NOP;
  endtask

  // Counts edges after edge 0 until done_o is seen (0 = never within budget).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_o) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rd_req_i = 1'b1;
    #1;
    vec_cnt++;
    if ({hi_o, lo_o, busy_o, ready_o, done_o, stall_o} !== {64'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset: hi=%h lo=%h busy=%b ready=%b done=%b stall=%b required 0 0 0 1 0 0",
               hi_o, lo_o, busy_o, ready_o, done_o, stall_o);
    end
    rd_req_i = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mult;
    int lat;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    vec_cnt++;
    if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
      err_cnt++; $display("FAIL mult_busy: busy=%b ready=%b required 1 0", busy_o, ready_o);
    end
    wait_done(lat);
    vec_cnt++;
    if (lat !== 33) begin err_cnt++; $display("FAIL mult_latency: got %0d required 33", lat); end
    vec_cnt++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFF1) begin
      err_cnt++; $display("FAIL mult_result: hi=%h lo=%h required ffffffff fffffff1", hi_o, lo_o);
    end
    vec_cnt++;
    if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL mult_idle: busy=%b required 0", busy_o); end
    @(posedge clk); #1;
    vec_cnt++;
    if (done_o !== 1'b0) begin err_cnt++; $display("FAIL mult_done_pulse: done=%b required 0", done_o); end
  endtask

  task automatic test_multu;
    int lat;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat);
    vec_cnt++;
    if (lat !== 33 || hi_o !== 32'h0000_0001 || lo_o !== 32'hFFFF_FFFE) begin
      err_cnt++; $display("FAIL multu: lat=%0d hi=%h lo=%h required 33 00000001 fffffffe", lat, hi_o, lo_o);
    end
  endtask

  task automatic test_madd_msub;
    int lat;
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd10, 32'd0);
    vec_cnt++;
    if (hi_o !== 32'd0 || lo_o !== 32'd10 || busy_o !== 1'b0) begin
      err_cnt++; $display("FAIL mthi_mtlo: hi=%h lo=%h busy=%b required 0 a 0", hi_o, lo_o, busy_o);
    end
    issue(OP_MADD, 32'd4, 32'd5);
    wait_done(lat);
    vec_cnt++;
    if (lat !== 33 || hi_o !== 32'd0 || lo_o !== 32'h1E) begin
      err_cnt++; $display("FAIL madd: lat=%0d hi=%h lo=%h required 33 0 1e", lat, hi_o, lo_o);
    end
    issue(OP_MSUB, 32'd1, 32'h1F);
    wait_done(lat);
    vec_cnt++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFF) begin
      err_cnt++; $display("FAIL msub: hi=%h lo=%h required ffffffff ffffffff", hi_o, lo_o);
    end
  endtask

  task automatic test_stall_flush;
    int lat;
    int bad;
    rd_req_i = 1'b1;
    issue(OP_MULT, 32'd7, 32'd9);
    bad = (stall_o !== 1'b1) ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_o) begin lat = k; break; end
      if (stall_o !== 1'b1) bad++;
    end
    vec_cnt++;
    if (bad != 0 || lat !== 33) begin
      err_cnt++; $display("FAIL stall_window: %0d cycles without stall, lat=%0d required 0 and 33", bad, lat);
    end
    vec_cnt++;
    if (stall_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd63) begin
      err_cnt++; $display("FAIL stall_release: stall=%b hi=%h lo=%h required 0 0 3f", stall_o, hi_o, lo_o);
    end
    rd_req_i = 1'b0;
    issue(OP_MULT, 32'd100, 32'd100);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    vec_cnt++;
    if (busy_o !== 1'b0 || ready_o !== 1'b1 || hi_o !== 32'd0 || lo_o !== 32'd63) begin
      err_cnt++; $display("FAIL flush: busy=%b ready=%b hi=%h lo=%h required 0 1 0 3f", busy_o, ready_o, hi_o, lo_o);
    end
    bad = 0;
    repeat (30) begin @(posedge clk); #1; if (done_o || busy_o) bad++; end
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL flush_quiet: %0d cycles with done/busy required 0", bad); end
    @(negedge clk);
    op_i = OP_MTHI; rs_i = 32'hCAFE_0001; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0; op_i = OP_NOP;
    vec_cnt++;
    if (hi_o !== 32'hCAFE_0001) begin err_cnt++; $display("FAIL flush_idle_mthi: hi=%h required cafe0001", hi_o); end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op_i = OP_MTHI; rs_i = 32'h1111_1111; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = OP_NOP;
    vec_cnt++;
    if (hi_o !== 32'hCAFE_0001 || busy_o !== 1'b1) begin
      err_cnt++; $display("FAIL start_while_busy: hi=%h busy=%b required cafe0001 1", hi_o, busy_o);
    end
    lat = 0;
    for (int k = 1; k <= 40; k++) begin @(posedge clk); #1; if (done_o) begin lat = k; break; end end
    issue(OP_MULTU, 32'd11, 32'd11);
    vec_cnt++;
    if (lat == 0 || busy_o !== 1'b1 || lo_o !== 32'd42) begin
      err_cnt++; $display("FAIL back_to_back_accept: busy=%b lo=%h required 1 2a", busy_o, lo_o);
    end
    wait_done(lat);
    vec_cnt++;
    if (lat !== 33 || lo_o !== 32'd121 || hi_o !== 32'd0) begin
      err_cnt++; $display("FAIL back_to_back_result: lat=%0d hi=%h lo=%h required 33 0 79", lat, hi_o, lo_o);
    end
  endtask

  task automatic test_div;
    int lat;
`ifdef HILO_DIV_EN
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    vec_cnt++;
    if (lat !== 33 || lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF) begin
      err_cnt++; $display("FAIL div_signed: lat=%0d hi=%h lo=%h required 33 ffffffff fffffffd", lat, hi_o, lo_o);
    end
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
    wait_done(lat);
    vec_cnt++;
    if (lo_o !== 32'h0FFF_FFFF || hi_o !== 32'hF) begin
      err_cnt++; $display("FAIL divu: hi=%h lo=%h required f 0fffffff", hi_o, lo_o);
    end
    issue(OP_DIVU, 32'd100, 32'd0);
    lat = 0;
    if (busy_o) lat++;
    repeat (3) begin @(posedge clk); #1; if (busy_o || done_o) lat++; end
    vec_cnt++;
    if (lat != 0 || hi_o !== 32'hF || lo_o !== 32'h0FFF_FFFF) begin
      err_cnt++; $display("FAIL div_by_zero: busy/done cycles=%0d hi=%h lo=%h required 0 f 0fffffff", lat, hi_o, lo_o);
    end
`else
    issue(OP_DIV, 32'd9, 32'd3);
    lat = busy_o ? 1 : 0;
    repeat (3) begin @(posedge clk); #1; if (busy_o || done_o) lat++; end
    vec_cnt++;
    if (lat != 0 || hi_o !== 32'd0 || lo_o !== 32'd121) begin
      err_cnt++; $display("FAIL div_disabled: busy/done cycles=%0d hi=%h lo=%h required 0 0 79", lat, hi_o, lo_o);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int lat;
    issue(OP_MULTU, 32'd5, 32'd5);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0 || ready_o !== 1'b1 || done_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b ready=%b done=%b required 0 0 0 1 0",
                          hi_o, lo_o, busy_o, ready_o, done_o);
    end
    @(negedge clk);
    rst = 1'b0; op_i = OP_MULT; rs_i = 32'hFFFF_FFFD; rt_i = 32'hFFFF_FFFD; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = OP_NOP;
    vec_cnt++;
    if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL reset_release_accept: busy=%b required 1", busy_o); end
    wait_done(lat);
    vec_cnt++;
    if (lat !== 33 || hi_o !== 32'd0 || lo_o !== 32'd9) begin
      err_cnt++; $display("FAIL reset_release_result: lat=%0d hi=%h lo=%h required 33 0 9", lat, hi_o, lo_o);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_madd_msub;
    test_stall_flush;
    test_back_to_back;
    test_div;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
